// File: rtl/data_store.sv
// Parametrised operand store: write port, registered random-read port and
// a wrapping block streamer with a valid/ready handshake.
module data_store #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 11,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_index,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_index,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             st_start,
    input  logic [AW-1:0]    st_base,
    input  logic [AW:0]      st_count,
    output logic [WIDTH-1:0] st_data,
    output logic             st_valid,
    input  logic             st_ready,
    output logic             st_last,
    output logic             st_busy,
    output logic             err
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0]   ONE      = (AW+1)'(1);
    localparam logic [AW:0]   TWO      = (AW+1)'(2);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } st_state_e;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             err_q;
    logic             err_d;

    st_state_e        state_q;
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;
    logic [AW:0]      rem_q;
    logic [WIDTH-1:0] st_data_q;
    logic             st_valid_q;
    logic             st_last_q;
    logic             st_busy_q;

    logic wr_ok;
    logic rd_ok;
    logic base_ok;
    logic start_req;
    logic accept;

    assign wr_ok   = {1'b0, wr_index} < DEPTH_W;
    assign rd_ok   = {1'b0, rd_index} < DEPTH_W;
    assign base_ok = {1'b0, st_base}  < DEPTH_W;

    // Zero-length requests are silently dropped and never flag an error.
    assign start_req = (state_q == S_IDLE) && st_start && (st_count != '0);
    assign accept    = st_valid_q && st_ready;
    assign ptr_d     = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;

    assign err_d = (wr_en && !wr_ok)
                 || (rd_en && !rd_ok)
                 || (start_req && !base_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && wr_ok) begin
            mem_q[wr_index] <= wr_data;
        end
    end

    // Reads sample mem_q before this edge's write lands: read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            err_q      <= err_d;
            if (rd_en) begin
                rd_data_q <= rd_ok ? mem_q[rd_index] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            st_data_q  <= '0;
            st_valid_q <= 1'b0;
            st_last_q  <= 1'b0;
            st_busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_req && base_ok) begin
                        state_q    <= S_RUN;
                        ptr_q      <= st_base;
                        rem_q      <= st_count;
                        st_data_q  <= mem_q[st_base];
                        st_valid_q <= 1'b1;
                        st_busy_q  <= 1'b1;
                        st_last_q  <= (st_count == ONE);
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (rem_q == ONE) begin
                            state_q    <= S_IDLE;
                            st_valid_q <= 1'b0;
                            st_busy_q  <= 1'b0;
                            st_last_q  <= 1'b0;
                        end else begin
                            ptr_q     <= ptr_d;
                            rem_q     <= rem_q - ONE;
                            st_data_q <= mem_q[ptr_d];
                            st_last_q <= (rem_q == TWO);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign st_data  = st_data_q;
    assign st_valid = st_valid_q;
    assign st_last  = st_last_q;
    assign st_busy  = st_busy_q;

endmodule

// File: tb/tb_data_store.sv
// Scoreboard bench for data_store: read and stream words are queued when
// requested and compared when the DUT presents them.
module tb_data_store;

    localparam int W  = 8;
    localparam int D  = 11;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_index;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_index;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          st_start;
    logic [AW-1:0] st_base;
    logic [AW:0]   st_count;
    logic [W-1:0]  st_data;
    logic          st_valid;
    logic          st_ready;
    logic          st_last;
    logic          st_busy;
    logic          err;

    data_store #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .rd_en(rd_en), .rd_index(rd_index),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .st_start(st_start), .st_base(st_base), .st_count(st_count),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_last(st_last), .st_busy(st_busy), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] model [D];
    logic [W-1:0] rd_q [$];
    logic [W:0]   st_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_stream(input int base, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            st_q.push_back({(k == cnt - 1), model[(base + k) % D]});
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid) begin
                if (rd_q.size() == 0) chk("rd_spurious", 32'(rd_valid), 0);
                else chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
            if (st_valid) begin
                if (st_q.size() == 0) begin
                    chk("st_spurious", 32'(st_valid), 0);
                end else begin
                    chk("st_data", 32'(st_data), 32'(st_q[0][W-1:0]));
                    chk("st_last", 32'(st_last), 32'(st_q[0][W]));
                    if (st_ready) void'(st_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int c;
        bit wrote;
        logic [3:0] pat;
        pat = 4'b1001;
        reset = 1'b1;
        wr_en = 0; wr_index = 0; wr_data = 0;
        rd_en = 0; rd_index = 0;
        st_start = 0; st_base = 0; st_count = 0; st_ready = 1;
        for (int i = 0; i < D; i++) model[i] = '0;
        #1;
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_st_valid", 32'(st_valid), 0);
        chk("rst_st_busy", 32'(st_busy), 0);
        chk("rst_err", 32'(err), 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < D; i++) begin
            rd_en = 1; rd_index = AW'(i); rd_q.push_back(model[i]);
            tick();
            chk("rd0_valid", 32'(rd_valid), 1);
            chk("rd0_err", 32'(err), 0);
        end
        rd_en = 0;

        for (int i = 0; i < D; i++) begin
            wr_en = 1; wr_index = AW'(i); wr_data = W'(8'h10 + i);
            model[i] = wr_data;
            tick();
        end
        wr_en = 0;
        rd_en = 1; rd_index = 3; rd_q.push_back(8'h13);
        tick();
        wr_en = 1; wr_index = 3; wr_data = 8'hAA; rd_q.push_back(8'h13);
        tick();
        model[3] = 8'hAA;
        wr_en = 0; rd_q.push_back(8'hAA);
        tick();
        rd_en = 0;
        tick();
        chk("rd_hold", 32'(rd_data), 32'h AA);
        chk("rd_pulse", 32'(rd_valid), 0);

        st_ready = 1; st_start = 1; st_base = 9; st_count = 4;
        push_stream(9, 4);
        tick();
        st_start = 0;
        for (int k = 0; k < 4; k++) begin
            chk("st_busy_run", 32'(st_busy), 1);
            tick();
        end
        chk("st_busy_end", 32'(st_busy), 0);
        chk("st_valid_end", 32'(st_valid), 0);
        chk("st_data_keep", 32'(st_data), 32'h11);

        st_start = 1; st_base = 9; st_count = 4;
        push_stream(9, 4);
        tick();
        st_start = 0;
        acc = 0; c = 0; wrote = 0;
        while (st_busy && c < 40) begin
            st_ready = pat[c % 4];
            if (!st_ready && !wrote) begin
                wr_en = 1; wr_index = AW'((9 + acc) % D); wr_data = 8'h55;
                model[(9 + acc) % D] = 8'h55;
                wrote = 1;
            end
            tick();
            wr_en = 0;
            if (st_ready) acc++;
            c++;
        end
        st_ready = 1;
        chk("stall_words", 32'(acc), 4);
        chk("stall_busy", 32'(st_busy), 0);

        wr_en = 1; wr_index = 11; wr_data = 8'h77;
        tick();
        wr_en = 0;
        chk("err_wr", 32'(err), 1);
        tick();
        chk("err_wr_pulse", 32'(err), 0);
        rd_en = 1; rd_index = 15; rd_q.push_back(8'h00);
        tick();
        rd_en = 0;
        chk("err_rd", 32'(err), 1);
        tick();
        chk("err_rd_pulse", 32'(err), 0);
        st_start = 1; st_base = 12; st_count = 3;
        tick();
        st_start = 0;
        chk("err_st", 32'(err), 1);
        chk("err_st_busy", 32'(st_busy), 0);
        tick();
        chk("err_st_pulse", 32'(err), 0);
        st_start = 1; st_base = 2; st_count = 0;
        tick();
        st_start = 0;
        chk("cnt0_err", 32'(err), 0);
        chk("cnt0_busy", 32'(st_busy), 0);
        for (int i = 0; i < D; i++) begin
            rd_en = 1; rd_index = AW'(i); rd_q.push_back(model[i]);
            tick();
        end
        rd_en = 0;
        tick();

        st_start = 1; st_base = 5; st_count = 11;
        push_stream(5, 11);
        tick();
        st_start = 0;
        tick();
        tick();
        chk("mid_word3", 32'(st_data), 32'(model[7]));
        #1;
        reset = 1'b1;
        #1;
        st_q.delete();
        for (int i = 0; i < D; i++) model[i] = '0;
        chk("mr_st_valid", 32'(st_valid), 0);
        chk("mr_st_busy", 32'(st_busy), 0);
        chk("mr_st_last", 32'(st_last), 0);
        chk("mr_st_data", 32'(st_data), 0);
        chk("mr_rd_data", 32'(rd_data), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < D; i++) begin
            rd_en = 1; rd_index = AW'(i); rd_q.push_back(model[i]);
            tick();
        end
        rd_en = 0;
        tick();
        tick();
        chk("rd_q_drained", 32'(rd_q.size()), 0);
        chk("st_q_drained", 32'(st_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
